// File: rtl/sram_data_responder.sv
// Data-side SRAM-like bus responder: word RAM with byte-lane writes
// behind an in-order response queue of fixed latency.
module sram_data_responder #(
  parameter int ADDR_W  = 12,
  parameter int LATENCY = 2,
  parameter int DEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata
);

  localparam int WORDS = 1 << (ADDR_W - 2);
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PW-1:0]     head;
  logic [PW-1:0]     tail;
  logic [2:0]        count;
  logic              qWr    [DEPTH];
  logic [31:0]       qSnap  [DEPTH];
  logic [2:0]        qTimer [DEPTH];
  logic [31:0]       mem    [WORDS];

  logic [ADDR_W-3:0] wordIdx;
  logic [3:0]        byteEn;
  logic              retire;
  logic              accept;
  logic              unusedAddr;

  assign wordIdx    = addr[ADDR_W-1:2];
  assign unusedAddr = ^addr[31:ADDR_W];

  // Everything below is a function of registered state only,
  // so addr_ok has no path from req.
  assign retire  = (count != 3'd0) && (qTimer[head] == 3'd0);
  assign addr_ok = (count < 3'(DEPTH)) || retire;
  assign accept  = req && addr_ok && rst;
  assign data_ok = retire;
  assign rdata   = (retire && !qWr[head]) ? qSnap[head] : '0;

  function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    byteEn = 4'b1111;
    unique case (1'b1)
      (size == 2'd0): byteEn = 4'b0001 << addr[1:0];
      (size == 2'd1): byteEn = addr[1] ? 4'b1100 : 4'b0011;
      default:        byteEn = 4'b1111;
    endcase
  end

  // RAM has no reset; contents survive rst.
  always_ff @(posedge clk) begin
    if (accept && wr) begin
      for (int i = 0; i < 4; i++) begin
        if (byteEn[i]) begin
          mem[wordIdx][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        qWr[i]    <= 1'b0;
        qSnap[i]  <= '0;
        qTimer[i] <= '0;
      end
    end else begin
      if (accept) tail <= nextPtr(tail);
      if (retire) head <= nextPtr(head);
      unique case (1'b1)
        (accept && !retire): count <= count + 3'd1;
        (!accept && retire): count <= count - 3'd1;
        default:             count <= count;
      endcase
      for (int i = 0; i < DEPTH; i++) begin
        if (accept && tail == PW'(i)) begin
          qWr[i]    <= wr;
          qSnap[i]  <= wr ? '0 : mem[wordIdx];
          qTimer[i] <= 3'(LATENCY - 1);
        end else if (qTimer[i] != 3'd0) begin
          qTimer[i] <= qTimer[i] - 3'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sram_data_responder.sv
// Directed and reference-model checks for sram_data_responder
// across three latency/depth configurations.
module tb_sram_data_responder;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   nChecks = 0;
  int   nErrors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic        reqA, wrA, addrOkA, dataOkA;
  logic [1:0]  sizeA;
  logic [31:0] addrA, wdataA, rdataA;
  logic        reqB, wrB, addrOkB, dataOkB;
  logic [1:0]  sizeB;
  logic [31:0] addrB, wdataB, rdataB;
  logic        reqC, wrC, addrOkC, dataOkC;
  logic [1:0]  sizeC;
  logic [31:0] addrC, wdataC, rdataC;

  sram_data_responder #(.LATENCY(2), .DEPTH(2)) dutA (
    .clk(clk), .rst(rst), .req(reqA), .wr(wrA),
    .size(sizeA), .addr(addrA), .wdata(wdataA),
    .addr_ok(addrOkA), .data_ok(dataOkA), .rdata(rdataA));

  sram_data_responder #(.LATENCY(4), .DEPTH(2)) dutB (
    .clk(clk), .rst(rst), .req(reqB), .wr(wrB),
    .size(sizeB), .addr(addrB), .wdata(wdataB),
    .addr_ok(addrOkB), .data_ok(dataOkB), .rdata(rdataB));

  sram_data_responder #(.LATENCY(3), .DEPTH(3)) dutC (
    .clk(clk), .rst(rst), .req(reqC), .wr(wrC),
    .size(sizeC), .addr(addrC), .wdata(wdataC),
    .addr_ok(addrOkC), .data_ok(dataOkC), .rdata(rdataC));

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  logic [31:0] gotA[$];
  int          gotACyc[$];
  int          gotBCyc[$];
  logic [31:0] expC[$];
  logic [31:0] refC[64];
  int          stallsA = 0;
  int          nAcc = 0;

  always @(negedge clk) begin
    if (dataOkA) begin
      gotA.push_back(rdataA);
      gotACyc.push_back(cyc);
    end
    if (dataOkB) gotBCyc.push_back(cyc);
    if (dataOkC) begin
      if (expC.size() == 0) check("dupC", {31'd0, dataOkC}, 32'd0);
      else check("respC", rdataC, expC.pop_front());
    end
  end

  function automatic logic [31:0] gotAt(input int i);
    return (i < gotA.size()) ? gotA[i] : 32'hxxxx_xxxx;
  endfunction

  function automatic bit laneOn(input logic [1:0] s,
                                input logic [1:0] a,
                                input logic [1:0] lane);
    case (s)
      2'd0:    return lane == a;
      2'd1:    return lane[1] == a[1];
      default: return 1'b1;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issueA(input logic w, input logic [1:0] s,
                        input logic [31:0] a, input logic [31:0] d);
    reqA = 1'b1; wrA = w; sizeA = s; addrA = a; wdataA = d;
    for (int k = 0; k < 20 && !addrOkA; k++) begin
      stallsA++;
      tick();
    end
    if (!addrOkA) check("acceptTimeoutA", {31'd0, addrOkA}, 32'd1);
    tick();
  endtask

  task automatic drainA();
    reqA = 1'b0;
    repeat (8) tick();
  endtask

  task automatic modelC();
    logic [5:0] idx;
    idx = addrC[7:2];
    nAcc++;
    if (wrC) begin
      for (int l = 0; l < 4; l++) begin
        if (laneOn(sizeC, addrC[1:0], 2'(l)))
          refC[idx][8*l +: 8] = wdataC[8*l +: 8];
      end
      expC.push_back(32'd0);
    end else begin
      expC.push_back(refC[idx]);
    end
  endtask

  int   accB[$];
  logic okAt2;
  int   accRel[8] = '{0, 1, 4, 5, 8, 9, 12, 13};

  initial begin
    reqA = 0; wrA = 0; sizeA = 0; addrA = 0; wdataA = 0;
    reqB = 0; wrB = 0; sizeB = 2; addrB = 0; wdataB = 0;
    reqC = 0; wrC = 0; sizeC = 0; addrC = 0; wdataC = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rstDataOk", {31'd0, dataOkA}, 32'd0);
    check("rstRdata", rdataA, 32'd0);
    rst = 1'b1;
    tick();
    check("addrOkAfterRst", {31'd0, addrOkA}, 32'd1);

    // cycle-exact word write then read
    reqA = 1; wrA = 1; sizeA = 2;
    addrA = 32'h10; wdataA = 32'hDEADBEEF;
    tick();
    check("wwDataOk1", {31'd0, dataOkA}, 32'd0);
    wrA = 0;
    tick();
    reqA = 0;
    check("wwDataOk2", {31'd0, dataOkA}, 32'd1);
    check("wwRdata2", rdataA, 32'd0);
    tick();
    check("wrDataOk3", {31'd0, dataOkA}, 32'd1);
    check("wrRdata3", rdataA, 32'hDEADBEEF);
    tick();
    check("wrIdle4", {31'd0, dataOkA}, 32'd0);
    repeat (3) tick();

    // sub-word lanes, plus seed 0x30 for ordering test
    gotA.delete();
    issueA(1, 2'd2, 32'h20, 32'h11223344);
    issueA(1, 2'd0, 32'h21, 32'h0000AA00);
    issueA(1, 2'd1, 32'h22, 32'hBBBB0000);
    issueA(0, 2'd2, 32'h20, 32'h0);
    issueA(1, 2'd2, 32'h30, 32'h5);
    drainA();
    check("subCount", gotA.size(), 32'd5);
    check("subWrResp", gotAt(0), 32'd0);
    check("subRead", gotAt(3), 32'hBBBBAA44);

    // read-before-write
    gotA.delete();
    issueA(0, 2'd2, 32'h30, 32'h0);
    issueA(1, 2'd2, 32'h30, 32'h9);
    issueA(0, 2'd3, 32'h30, 32'h0);
    drainA();
    check("rbwCount", gotA.size(), 32'd3);
    check("rbwOld", gotAt(0), 32'h5);
    check("rbwWr", gotAt(1), 32'h0);
    check("rbwNew", gotAt(2), 32'h9);

    // streaming reads
    for (int i = 0; i < 8; i++)
      issueA(1, 2'd2, 32'h40 + 4 * i, 32'hA0 + i);
    drainA();
    gotA.delete();
    gotACyc.delete();
    stallsA = 0;
    for (int i = 0; i < 8; i++)
      issueA(0, 2'd2, 32'h40 + 4 * i, 32'h0);
    drainA();
    check("streamStalls", stallsA, 32'd0);
    check("streamCount", gotA.size(), 32'd8);
    if (gotA.size() == 8) begin
      for (int i = 0; i < 8; i++) begin
        check("streamData", gotA[i], 32'hA0 + i);
        check("streamCyc", gotACyc[i] - gotACyc[0], i);
      end
    end

    // reset with two reads in flight
    gotA.delete();
    issueA(0, 2'd2, 32'h40, 32'h0);
    issueA(0, 2'd2, 32'h44, 32'h0);
    reqA = 0;
    check("preRstDataOk", {31'd0, dataOkA}, 32'd1);
    check("preRstRdata", rdataA, 32'hA0);
    rst = 1'b0;
    #1;
    check("midRstDataOk", {31'd0, dataOkA}, 32'd0);
    check("midRstRdata", rdataA, 32'd0);
    tick();
    tick();
    rst = 1'b1;
    repeat (6) tick();
    check("noStale", gotA.size(), 32'd0);
    check("addrOkPostRst", {31'd0, addrOkA}, 32'd1);
    issueA(0, 2'd2, 32'h10, 32'h0);
    drainA();
    check("ramRetained", gotAt(0), 32'hDEADBEEF);

    // back-pressure: LATENCY 4, DEPTH 2
    okAt2 = 1'b1;
    reqB = 1'b1;
    for (int k = 0; k < 40 && accB.size() < 8; k++) begin
      if (k == 2) okAt2 = addrOkB;
      if (addrOkB) accB.push_back(cyc);
      tick();
    end
    reqB = 1'b0;
    repeat (12) tick();
    check("bAccepts", accB.size(), 32'd8);
    check("bStallAt2", {31'd0, okAt2}, 32'd0);
    check("bResponses", gotBCyc.size(), 32'd8);
    if (accB.size() == 8 && gotBCyc.size() == 8) begin
      for (int i = 0; i < 8; i++)
        check("bAccCyc", accB[i] - accB[0], accRel[i]);
      check("bFirstResp", gotBCyc[0] - accB[0], 32'd4);
      check("bLastResp", gotBCyc[7] - gotBCyc[0], 32'd13);
    end

    // random stream against reference queue: seed RAM first
    for (int w = 0; w < 64; w++) begin
      reqC = 1; wrC = 1; sizeC = 2;
      addrC = {24'd0, 6'(w), 2'd0};
      wdataC = $urandom;
      for (int k = 0; k < 20 && !addrOkC; k++) tick();
      if (addrOkC) modelC();
      else check("cInitTimeout", {31'd0, addrOkC}, 32'd1);
      tick();
    end
    nAcc = 0;
    for (int k = 0; k < 20000 && nAcc < 1000; k++) begin
      reqC   = ($urandom_range(0, 3) != 0);
      wrC    = 1'($urandom_range(0, 1));
      sizeC  = 2'($urandom_range(0, 3));
      addrC  = {20'($urandom_range(0, 1048575)), 4'd0,
                6'($urandom_range(0, 63)),
                2'($urandom_range(0, 3))};
      wdataC = $urandom;
      if (reqC && addrOkC) modelC();
      tick();
    end
    reqC = 1'b0;
    repeat (15) tick();
    check("cAccepted", nAcc, 32'd1000);
    check("cPending", expC.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule
